// File: rtl/mcpu_pkg.sv
// Shared encodings for the multi-cycle CPU controller: state codes, opcodes,
// datapath select codes and the packed bundle of decoded control outputs.
package mcpu_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_ALU_WB   = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_JAL      = 4'd10,
        S_JR       = 4'd11,
        S_ADDI_EX  = 4'd12,
        S_ADDI_WB  = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FUNCT_JR = 6'b001000;

    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;

    localparam logic [1:0] RDST_RT  = 2'd0;
    localparam logic [1:0] RDST_RD  = 2'd1;
    localparam logic [1:0] RDST_R31 = 2'd2;

    localparam logic [1:0] ASB_RT      = 2'd0;
    localparam logic [1:0] ASB_FOUR    = 2'd1;
    localparam logic [1:0] ASB_IMM     = 2'd2;
    localparam logic [1:0] ASB_IMM_SH2 = 2'd3;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] PCS_ALU    = 2'd0;
    localparam logic [1:0] PCS_ALUOUT = 2'd1;
    localparam logic [1:0] PCS_JUMP   = 2'd2;
    localparam logic [1:0] PCS_RS     = 2'd3;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] mem_to_reg;
        logic [1:0] reg_dst;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
        logic       timeout;
    } ctrl_t;

    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-style control FSM with memory wait-timeout.
// Latency: one state per clk_i; outputs decoded from state (enables gated by mem_ready_i).
// Backpressure: FETCH/MEM_RD/MEM_WR stall on mem_ready_i, aborting after WAIT_MAX waits.
module multi_cycle_ctrl
    import mcpu_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       pc_write_cond_o,
    output logic       branch_ne_o,
    output logic       iord_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       reg_write_o,
    output logic       alu_src_a_o,
    output logic [1:0] mem_to_reg_o,
    output logic [1:0] reg_dst_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic [1:0] pc_source_o,
    output logic       illegal_o,
    output logic       timeout_o,
    output logic [3:0] state_o
);

    localparam int              CW      = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(WAIT_MAX);
    localparam logic [CW-1:0]   CNT_ONE = CW'(1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_wait_cnt;
    logic [CW-1:0] w_wait_cnt_nxt;
    logic          w_in_wait;
    logic          w_timeout;
    ctrl_t         w_ctrl;
    ctrl_t         w_out;
    logic          w_unused_zero;

    // The zero flag is resolved in the datapath via pc_write_cond/branch_ne.
    assign w_unused_zero = zero_i;

    assign w_in_wait = is_wait_state(r_state);
    assign w_timeout = w_in_wait && !mem_ready_i && (r_wait_cnt == CNT_MAX);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ctrl      = '0;
        case (r_state)
            S_FETCH: begin
                w_ctrl.mem_read  = 1'b1;
                w_ctrl.alu_src_b = ASB_FOUR;
                w_ctrl.alu_op    = ALU_ADD;
                w_ctrl.pc_source = PCS_ALU;
                if (mem_ready_i) begin
                    w_ctrl.ir_write = 1'b1;
                    w_ctrl.pc_write = 1'b1;
                    w_state_nxt     = S_DECODE;
                end
            end
            S_DECODE: begin
                w_ctrl.alu_src_b = ASB_IMM_SH2;
                w_ctrl.alu_op    = ALU_ADD;
                case (op_i)
                    OP_RTYPE:       w_state_nxt = (funct_i == FUNCT_JR) ? S_JR : S_EXEC;
                    OP_LW, OP_SW:   w_state_nxt = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: w_state_nxt = S_BRANCH;
                    OP_ADDI:        w_state_nxt = S_ADDI_EX;
                    OP_J:           w_state_nxt = S_JUMP;
                    OP_JAL:         w_state_nxt = S_JAL;
                    default: begin
                        w_ctrl.illegal = 1'b1;
                        w_state_nxt    = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = ASB_IMM;
                w_ctrl.alu_op    = ALU_ADD;
                w_state_nxt      = (op_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                w_ctrl.iord     = 1'b1;
                w_ctrl.mem_read = 1'b1;
                if (mem_ready_i) w_state_nxt = S_MEM_WB;
            end
            S_MEM_WR: begin
                w_ctrl.iord      = 1'b1;
                w_ctrl.mem_write = 1'b1;
                if (mem_ready_i) w_state_nxt = S_FETCH;
            end
            S_MEM_WB: begin
                w_ctrl.reg_dst    = RDST_RT;
                w_ctrl.mem_to_reg = M2R_MDR;
                w_ctrl.reg_write  = 1'b1;
                w_state_nxt       = S_FETCH;
            end
            S_EXEC: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = ASB_RT;
                w_ctrl.alu_op    = ALU_FUNCT;
                w_state_nxt      = S_ALU_WB;
            end
            S_ALU_WB: begin
                w_ctrl.reg_dst    = RDST_RD;
                w_ctrl.mem_to_reg = M2R_ALUOUT;
                w_ctrl.reg_write  = 1'b1;
                w_state_nxt       = S_FETCH;
            end
            S_BRANCH: begin
                w_ctrl.alu_src_a     = 1'b1;
                w_ctrl.alu_src_b     = ASB_RT;
                w_ctrl.alu_op        = ALU_SUB;
                w_ctrl.pc_write_cond = 1'b1;
                w_ctrl.pc_source     = PCS_ALUOUT;
                w_ctrl.branch_ne     = (op_i == OP_BNE);
                w_state_nxt          = S_FETCH;
            end
            S_JUMP: begin
                w_ctrl.pc_write  = 1'b1;
                w_ctrl.pc_source = PCS_JUMP;
                w_state_nxt      = S_FETCH;
            end
            S_JAL: begin
                w_ctrl.pc_write   = 1'b1;
                w_ctrl.pc_source  = PCS_JUMP;
                w_ctrl.reg_dst    = RDST_R31;
                w_ctrl.mem_to_reg = M2R_PC;
                w_ctrl.reg_write  = 1'b1;
                w_state_nxt       = S_FETCH;
            end
            S_JR: begin
                w_ctrl.pc_write  = 1'b1;
                w_ctrl.pc_source = PCS_RS;
                w_state_nxt      = S_FETCH;
            end
            S_ADDI_EX: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = ASB_IMM;
                w_ctrl.alu_op    = ALU_ADD;
                w_state_nxt      = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                w_ctrl.reg_dst    = RDST_RT;
                w_ctrl.mem_to_reg = M2R_ALUOUT;
                w_ctrl.reg_write  = 1'b1;
                w_state_nxt       = S_FETCH;
            end
            default: w_state_nxt = S_FETCH;
        endcase

        // An aborted access must leave no architectural or memory side effect.
        if (w_timeout) begin
            w_ctrl.timeout   = 1'b1;
            w_ctrl.pc_write  = 1'b0;
            w_ctrl.ir_write  = 1'b0;
            w_ctrl.reg_write = 1'b0;
            w_ctrl.mem_write = 1'b0;
            w_state_nxt      = S_FETCH;
        end
    end

    always_comb begin
        w_wait_cnt_nxt = '0;
        if ((w_state_nxt == r_state) && !w_timeout && w_in_wait && !mem_ready_i)
            w_wait_cnt_nxt = r_wait_cnt + CNT_ONE;
    end

    assign w_out = rst_i ? w_ctrl : '0;

    assign pc_write_o      = w_out.pc_write;
    assign pc_write_cond_o = w_out.pc_write_cond;
    assign branch_ne_o     = w_out.branch_ne;
    assign iord_o          = w_out.iord;
    assign mem_read_o      = w_out.mem_read;
    assign mem_write_o     = w_out.mem_write;
    assign ir_write_o      = w_out.ir_write;
    assign reg_write_o     = w_out.reg_write;
    assign alu_src_a_o     = w_out.alu_src_a;
    assign mem_to_reg_o    = w_out.mem_to_reg;
    assign reg_dst_o       = w_out.reg_dst;
    assign alu_src_b_o     = w_out.alu_src_b;
    assign alu_op_o        = w_out.alu_op;
    assign pc_source_o     = w_out.pc_source;
    assign illegal_o       = w_out.illegal;
    assign timeout_o       = w_out.timeout;
    assign state_o         = rst_i ? r_state : 4'd0;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: per-instruction expected cycle traces built from
// the instruction class and planned memory waits, checked every cycle.
module tb_multi_cycle_ctrl;

    localparam int WAIT_MAX = 15;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [5:0] op_i;
    logic [5:0] funct_i;
    logic       zero_i;
    logic       mem_ready_i;
    logic       pc_write_o, pc_write_cond_o, branch_ne_o, iord_o;
    logic       mem_read_o, mem_write_o, ir_write_o, reg_write_o, alu_src_a_o;
    logic [1:0] mem_to_reg_o, reg_dst_o, alu_src_b_o, alu_op_o, pc_source_o;
    logic       illegal_o, timeout_o;
    logic [3:0] state_o;

    multi_cycle_ctrl #(.WAIT_MAX(WAIT_MAX)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .op_i(op_i), .funct_i(funct_i),
        .zero_i(zero_i), .mem_ready_i(mem_ready_i),
        .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o),
        .branch_ne_o(branch_ne_o), .iord_o(iord_o), .mem_read_o(mem_read_o),
        .mem_write_o(mem_write_o), .ir_write_o(ir_write_o), .reg_write_o(reg_write_o),
        .alu_src_a_o(alu_src_a_o), .mem_to_reg_o(mem_to_reg_o), .reg_dst_o(reg_dst_o),
        .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o), .pc_source_o(pc_source_o),
        .illegal_o(illegal_o), .timeout_o(timeout_o), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, pcwc, bne, iord, mr, mw, irw, rw, asa;
        logic [1:0] m2r, rdst, asb, aluop, pcs;
        logic       ill, to;
    } obs_t;

    typedef struct packed {
        logic rdy;
        obs_t o;
    } step_t;

    obs_t  got;
    step_t q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    assign got = {state_o, pc_write_o, pc_write_cond_o, branch_ne_o, iord_o, mem_read_o,
                  mem_write_o, ir_write_o, reg_write_o, alu_src_a_o, mem_to_reg_o,
                  reg_dst_o, alu_src_b_o, alu_op_o, pc_source_o, illegal_o, timeout_o};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    function automatic obs_t at(input logic [3:0] s);
        obs_t o = '0;
        o.st = s;
        return o;
    endfunction

    task automatic push(input logic rdy, input obs_t o);
        step_t s;
        s.rdy = rdy;
        s.o   = o;
        q.push_back(s);
    endtask

    function automatic logic any_rdy();
        return 1'($urandom_range(0, 1));
    endfunction

    // k idle memory cycles precede the ready; more than WAIT_MAX idles means abort.
    task automatic mem_phase(input obs_t base, input obs_t done, input int k, output bit ok);
        obs_t t;
        for (int j = 0; j < k && j < WAIT_MAX; j++) push(1'b0, base);
        if (k > WAIT_MAX) begin
            t    = base;
            t.mw = 1'b0;
            t.to = 1'b1;
            push(1'b0, t);
            ok = 1'b0;
        end else begin
            push(1'b1, done);
            ok = 1'b1;
        end
    endtask

    function automatic bit legal_op(input logic [5:0] op);
        return op inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h08, 6'h02, 6'h03};
    endfunction

    task automatic build(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
        obs_t b, d;
        bit   ok;
        b = at(4'd0); b.mr = 1'b1; b.asb = 2'd1;
        d = b; d.irw = 1'b1; d.pcw = 1'b1;
        mem_phase(b, d, fw, ok);
        if (!ok) return;
        b = at(4'd1); b.asb = 2'd3;
        if (!legal_op(op)) begin
            b.ill = 1'b1;
            push(any_rdy(), b);
            return;
        end
        push(any_rdy(), b);
        case (op)
            6'h00: begin
                if (fn == 6'h08) begin
                    b = at(4'd11); b.pcw = 1'b1; b.pcs = 2'd3; push(any_rdy(), b);
                end else begin
                    b = at(4'd6); b.asa = 1'b1; b.aluop = 2'd2; push(any_rdy(), b);
                    b = at(4'd7); b.rdst = 2'd1; b.rw = 1'b1; push(any_rdy(), b);
                end
            end
            6'h23, 6'h2b: begin
                b = at(4'd2); b.asa = 1'b1; b.asb = 2'd2; push(any_rdy(), b);
                if (op == 6'h23) begin
                    b = at(4'd3); b.iord = 1'b1; b.mr = 1'b1;
                    mem_phase(b, b, mw, ok);
                    if (ok) begin
                        b = at(4'd4); b.m2r = 2'd1; b.rw = 1'b1; push(any_rdy(), b);
                    end
                end else begin
                    b = at(4'd5); b.iord = 1'b1; b.mw = 1'b1;
                    mem_phase(b, b, mw, ok);
                end
            end
            6'h04, 6'h05: begin
                b = at(4'd8); b.asa = 1'b1; b.aluop = 2'd1; b.pcwc = 1'b1; b.pcs = 2'd1;
                b.bne = (op == 6'h05);
                push(any_rdy(), b);
            end
            6'h08: begin
                b = at(4'd12); b.asa = 1'b1; b.asb = 2'd2; push(any_rdy(), b);
                b = at(4'd13); b.rw = 1'b1; push(any_rdy(), b);
            end
            6'h02: begin
                b = at(4'd9); b.pcw = 1'b1; b.pcs = 2'd2; push(any_rdy(), b);
            end
            default: begin
                b = at(4'd10); b.pcw = 1'b1; b.pcs = 2'd2; b.rdst = 2'd2; b.m2r = 2'd2;
                b.rw = 1'b1;
                push(any_rdy(), b);
            end
        endcase
    endtask

    // Called on a falling edge; drives each planned cycle and checks it mid-cycle.
    task automatic run(input string tag, input int max_steps);
        step_t s;
        int    i = 0;
        while (q.size() > 0 && (max_steps < 0 || i < max_steps)) begin
            s           = q.pop_front();
            mem_ready_i = s.rdy;
            zero_i      = any_rdy();
            #1 chk($sformatf("%s[%0d]", tag, i), {7'd0, got}, {7'd0, s.o});
            i++;
            @(negedge clk_i);
        end
    endtask

    task automatic instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                         input int fw, input int mw);
        op_i    = op;
        funct_i = fn;
        q.delete();
        build(op, fn, fw, mw);
        run(tag, -1);
    endtask

    function automatic int rand_wait();
        int r = int'($urandom_range(0, 9));
        if (r < 6) return int'($urandom_range(0, 3));
        if (r < 8) return WAIT_MAX;
        return WAIT_MAX + 1 + int'($urandom_range(0, 3));
    endfunction

    initial begin
        logic [5:0] op, fn;
        int         pick;
        rst_i       = 1'b0;
        mem_ready_i = 1'b1;
        zero_i      = 1'b0;
        op_i        = 6'h23;
        funct_i     = 6'h20;
        #1 chk("reset_outputs", {7'd0, got}, 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        chk("reset_held", {7'd0, got}, 32'd0);
        rst_i = 1'b1;

        instr("lw_fast", 6'h23, 6'h00, 0, 0);
        instr("sw_wait3", 6'h2b, 6'h00, 0, 3);
        instr("fetch_stuck", 6'h23, 6'h00, WAIT_MAX + 5, 0);
        instr("fetch_edge", 6'h23, 6'h00, WAIT_MAX, WAIT_MAX);
        instr("sw_timeout", 6'h2b, 6'h00, 1, WAIT_MAX + 1);
        instr("lw_timeout", 6'h23, 6'h00, 2, WAIT_MAX + 2);
        instr("illegal", 6'h3f, 6'h00, 0, 0);
        instr("jal", 6'h03, 6'h00, 1, 0);
        instr("jr", 6'h00, 6'h08, 0, 0);
        instr("beq", 6'h04, 6'h00, 0, 0);
        instr("bne", 6'h05, 6'h00, 2, 0);

        // Reset asserted between edges while a load is waiting on memory.
        op_i    = 6'h23;
        funct_i = 6'h00;
        q.delete();
        build(6'h23, 6'h00, 0, 6);
        run("lw_pre_rst", 4);
        mem_ready_i = 1'b1;
        #2 rst_i = 1'b0;
        #1 chk("rst_mid_access", {7'd0, got}, 32'd0);
        @(posedge clk_i);
        #1 chk("rst_mid_hold", {7'd0, got}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        instr("after_rst", 6'h08, 6'h00, 2, 0);

        for (int n = 0; n < 60; n++) begin
            pick = int'($urandom_range(0, 9));
            fn   = 6'($urandom_range(0, 63));
            case (pick)
                0: op = 6'h23;
                1: op = 6'h2b;
                2: op = 6'h04;
                3: op = 6'h05;
                4: op = 6'h08;
                5: op = 6'h02;
                6: op = 6'h03;
                7: op = 6'h00;
                8: begin op = 6'h00; fn = 6'h08; end
                default: begin
                    op = 6'($urandom_range(0, 63));
                    while (legal_op(op)) op = 6'($urandom_range(0, 63));
                end
            endcase
            instr($sformatf("rnd%0d_op%h", n, op), op, fn, rand_wait(), rand_wait());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
